// File: rtl/sr_latch_trng.sv
// SR-latch entropy source: XOR of an excited latch array, a von Neumann debiaser,
// a repetition-count health test and word packing behind a valid/ready handshake.

module sr_latch (
    input  logic s,
    input  logic r,
    output logic q
);
    // Reset-dominant; in silicon the s=r=1 phase is what provokes metastability.
    always_latch begin
        if (r)
            q <= 1'b0;
        else if (s)
            q <= 1'b1;
    end
endmodule

module sr_latch_trng #(
    parameter int NUM_LATCHES = 8,
    parameter int WORD_WIDTH  = 8,
    parameter int REP_LIMIT   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enabled,
    input  logic                  test_mode,
    input  logic                  test_bit,
    input  logic                  debias_en,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  health_fail,
    output logic                  b
);
    localparam int CNT_W = $clog2(WORD_WIDTH + 1);
    localparam int RUN_W = $clog2(REP_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_WIDTH);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(REP_LIMIT);

    typedef enum logic {DB_EMPTY, DB_HALF} db_state_t;

    function automatic logic [RUN_W-1:0] run_next(input logic [RUN_W-1:0] run,
                                                  input logic             same);
        if (run == '0 || !same)
            return RUN_W'(1);
        if (run == RUN_MAX)
            return RUN_MAX;
        return run + RUN_W'(1);
    endfunction

    logic                   excite;
    logic                   latch_s;
    logic                   latch_r;
    logic [NUM_LATCHES-1:0] latch_q;

    // Outside operation every latch is parked in its reset-hold state.
    assign excite  = enabled & rst_n;
    assign latch_s = excite & clk;
    assign latch_r = excite ? clk : 1'b1;

    for (genvar i = 0; i < NUM_LATCHES; i++) begin : g_latch
        sr_latch u_latch (
            .s (latch_s),
            .r (latch_r),
            .q (latch_q[i])
        );
    end

    logic                  sample_q, sample_d;
    logic                  sample_vld_q, sample_vld_d;
    logic                  prev_q, prev_d;
    logic [RUN_W-1:0]      run_q, run_d;
    db_state_t             db_state_q, db_state_d;
    logic                  db_bit_q, db_bit_d;
    logic                  debias_en_q, debias_en_d;
    logic [WORD_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  health_fail_q, health_fail_d;

    logic                  raw_bit;
    logic                  handshake;
    logic                  slot_free;
    logic                  emit;
    logic                  emit_bit;
    logic                  trip;
    db_state_t             db_cur;
    logic [RUN_W-1:0]      run_n;
    logic [WORD_WIDTH-1:0] acc_n;

    always_comb begin
        raw_bit      = test_mode ? test_bit : ^latch_q;
        sample_d     = enabled ? raw_bit : sample_q;
        sample_vld_d = enabled;
    end

    always_comb begin
        prev_d        = prev_q;
        run_d         = run_q;
        db_bit_d      = db_bit_q;
        debias_en_d   = debias_en;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        health_fail_d = health_fail_q;
        handshake     = out_valid_q & out_ready;
        slot_free     = ~out_valid_q | out_ready;
        emit          = 1'b0;
        emit_bit      = 1'b0;
        trip          = 1'b0;
        run_n         = run_q;
        db_cur        = (debias_en != debias_en_q) ? DB_EMPTY : db_state_q;
        db_state_d    = db_cur;
        acc_n         = {acc_q[WORD_WIDTH-2:0], 1'b0};

        if (health_fail_q) begin
            run_d       = '0;
            db_state_d  = DB_EMPTY;
            acc_d       = '0;
            cnt_d       = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
        end else begin
            if (handshake)
                out_valid_d = 1'b0;

            // A gap in samples (enable was low) restarts the stream; a held word survives.
            if (!sample_vld_q) begin
                run_d      = '0;
                db_state_d = DB_EMPTY;
                if (cnt_q != CNT_FULL) begin
                    acc_d = '0;
                    cnt_d = '0;
                end
            end else begin
                run_n  = run_next(run_q, sample_q == prev_q);
                run_d  = run_n;
                prev_d = sample_q;
                if (run_n == RUN_MAX) begin
                    trip = 1'b1;
                end else if (!debias_en) begin
                    emit     = 1'b1;
                    emit_bit = sample_q;
                end else if (db_cur == DB_EMPTY) begin
                    db_bit_d   = sample_q;
                    db_state_d = DB_HALF;
                end else begin
                    db_state_d = DB_EMPTY;
                    emit       = (sample_q != db_bit_q);
                    emit_bit   = db_bit_q;
                end
            end

            acc_n = {acc_q[WORD_WIDTH-2:0], emit_bit};
            if (cnt_q == CNT_FULL) begin
                if (handshake) begin
                    out_data_d  = acc_q;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                end
            end else if (emit) begin
                if (cnt_q == CNT_FULL - CNT_W'(1)) begin
                    if (slot_free) begin
                        out_data_d  = acc_n;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                    end else begin
                        acc_d = acc_n;
                        cnt_d = CNT_FULL;
                    end
                end else begin
                    acc_d = acc_n;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            if (trip) begin
                health_fail_d = 1'b1;
                db_state_d    = DB_EMPTY;
                acc_d         = '0;
                cnt_d         = '0;
                out_data_d    = '0;
                out_valid_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q      <= 1'b0;
            sample_vld_q  <= 1'b0;
            prev_q        <= 1'b0;
            run_q         <= '0;
            db_state_q    <= DB_EMPTY;
            db_bit_q      <= 1'b0;
            debias_en_q   <= 1'b0;
            acc_q         <= '0;
            cnt_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            sample_q      <= sample_d;
            sample_vld_q  <= sample_vld_d;
            prev_q        <= prev_d;
            run_q         <= run_d;
            db_state_q    <= db_state_d;
            db_bit_q      <= db_bit_d;
            debias_en_q   <= debias_en_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            health_fail_q <= health_fail_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign health_fail = health_fail_q;
    assign b           = sample_q;

endmodule

// File: tb/tb_sr_latch_trng.sv
// Scoreboard bench for sr_latch_trng: expected words queued by the stimulus,
// consumed words checked by an independent monitor.

module tb_sr_latch_trng;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       enabled;
    logic       test_mode;
    logic       test_bit;
    logic       debias_en;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       health_fail;
    logic       b;

    int         tests = 0;
    int         fails = 0;
    int         stall = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_word;
    bit         seg_bits[$];

    sr_latch_trng #(
        .NUM_LATCHES (8),
        .WORD_WIDTH  (8),
        .REP_LIMIT   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enabled     (enabled),
        .test_mode   (test_mode),
        .test_bit    (test_bit),
        .debias_en   (debias_en),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .health_fail (health_fail),
        .b           (b)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Monitor: a word is consumed on any edge that sees valid and ready together.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_word: got %02h, required no word", out_data);
            end else begin
                exp_word = exp_q.pop_front();
                if (out_data !== exp_word) begin
                    fails++;
                    $display("FAIL word: got %02h, required %02h", out_data, exp_word);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic v);
        test_bit = v;
        tick();
    endtask

    task automatic feed_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) feed(w[i]);
    endtask

    task automatic rand_ready();
        if (out_valid) stall++;
        else stall = 0;
        out_ready = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    // Reference: pair-wise von Neumann selection, then MSB-first chunking into bytes;
    // a trailing partial word is lost when the segment ends with enabled dropping.
    task automatic model_push(input bit db);
        bit         em[$];
        logic [7:0] w;
        em = {};
        if (db) begin
            for (int i = 0; i + 1 < seg_bits.size(); i += 2)
                if (seg_bits[i] != seg_bits[i+1]) em.push_back(seg_bits[i]);
        end else begin
            em = seg_bits;
        end
        for (int k = 0; k + 8 <= em.size(); k += 8) begin
            w = '0;
            for (int j = 0; j < 8; j++) w = {w[6:0], em[k+j]};
            exp_q.push_back(w);
        end
    endtask

    initial begin
        logic [7:0]  w_b2;
        logic [7:0]  w_4d;
        logic [7:0]  w_disc;
        logic [23:0] dseq;
        w_b2   = 8'hB2;
        w_4d   = 8'h4D;
        w_disc = 8'b1110_0011;
        dseq   = 24'b10_11_01_00_10_01_10_01_01_10_01_10;

        rst_n     = 1'b0;
        enabled   = 1'b0;
        test_mode = 1'b1;
        test_bit  = 1'b0;
        debias_en = 1'b0;
        out_ready = 1'b0;
        #3;
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_health", health_fail, 0);
        check("rst_b", b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Packing, hold under backpressure, held second word, discard of extra bits.
        enabled = 1'b1;
        feed_word(w_b2);
        check("pack_latency", out_valid, 0);
        check("pack_b_last", b, 0);
        feed(w_4d[7]);
        check("pack_valid", out_valid, 1);
        check("pack_data", out_data, 8'hB2);
        for (int i = 6; i >= 0; i--) begin
            feed(w_4d[i]);
            check("hold_b2", {out_valid, out_data}, {1'b1, 8'hB2});
        end
        for (int i = 7; i >= 0; i--) begin
            feed(w_disc[i]);
            check("hold_b2", {out_valid, out_data}, {1'b1, 8'hB2});
        end
        enabled = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_b2", {out_valid, out_data}, {1'b1, 8'hB2});
        end
        exp_q.push_back(8'hB2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_next_valid", out_valid, 1);
        check("bp_next_data", out_data, 8'h4D);
        for (int i = 0; i < 5; i++) tick();
        check("bp_held_4d", {out_valid, out_data}, {1'b1, 8'h4D});
        exp_q.push_back(8'h4D);
        out_ready = 1'b1;
        tick();
        check("bp_drain", out_valid, 0);
        for (int i = 0; i < 10; i++) tick();

        // Asynchronous reset mid-word and mid-cycle.
        enabled = 1'b1;
        feed(1'b1);
        feed(1'b0);
        feed(1'b1);
        check("mid_b_before", b, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_health", health_fail, 0);
        check("mid_rst_b", b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(8'h5C);
        feed_word(8'h5C);
        enabled = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // enabled dropping discards the partial word.
        enabled = 1'b1;
        feed(1'b1); feed(1'b1); feed(1'b0); feed(1'b1); feed(1'b1);
        enabled = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        enabled = 1'b1;
        exp_q.push_back(8'h96);
        feed_word(8'h96);
        enabled = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Debiaser on the documented pair sequence.
        debias_en = 1'b1;
        tick();
        tick();
        exp_q.push_back(8'hA9);
        enabled = 1'b1;
        for (int i = 23; i >= 0; i--) feed(dseq[i]);
        enabled = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("debias_drained", exp_q.size(), 0);
        debias_en = 1'b0;
        tick();

        // Randomised segments with random consumer stalls.
        for (int s = 0; s < 12; s++) begin
            bit db;
            int len;
            int run;
            bit last;
            db        = 1'($urandom_range(0, 1));
            len       = $urandom_range(16, 120);
            debias_en = db;
            enabled   = 1'b0;
            tick(); rand_ready();
            tick(); rand_ready();
            seg_bits = {};
            run  = 0;
            last = 1'b0;
            for (int i = 0; i < len; i++) begin
                bit v;
                v = 1'($urandom_range(0, 1));
                if (i > 0 && v == last) run++;
                else run = 1;
                if (run > 12) begin
                    v   = ~last;
                    run = 1;
                end
                seg_bits.push_back(v);
                last = v;
            end
            model_push(db);
            enabled = 1'b1;
            for (int i = 0; i < len; i++) begin
                feed(seg_bits[i]);
                rand_ready();
            end
            enabled = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                rand_ready();
            end
        end
        out_ready = 1'b1;
        debias_en = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("random_drained", exp_q.size(), 0);

        // Repetition-count health test.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        enabled = 1'b1;
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 16; i++) feed(1'b1);
        check("health_before", health_fail, 0);
        feed(1'b1);
        check("health_trip", health_fail, 1);
        check("health_valid", out_valid, 0);
        check("health_data", out_data, 0);
        for (int i = 0; i < 20; i++) begin
            enabled = ((i / 4) % 2 == 0);
            feed(1'($urandom_range(0, 1)));
        end
        check("health_sticky", health_fail, 1);
        check("health_no_word", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("health_cleared", health_fail, 0);
        @(negedge clk);
        rst_n = 1'b1;
        enabled = 1'b0;
        tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sr_latch_trng.md
# sr_latch_trng

Parametrised successor to the SR-latch entropy source. It excites a configurable array of NUM_LATCHES SR latches and XOR-reduces their outputs into one registered raw bit. That bit then passes through an optional von Neumann debiaser and a repetition-count health test, and is packed into WORD_WIDTH-bit words. Words are delivered over a valid/ready handshake. A test-mode bypass replaces the latch array with a deterministic input so the digital path can be verified.

## Interface
- NUM_LATCHES, default 8: number of sr_latch instances XOR-reduced per sample; minimum 1.
- WORD_WIDTH, default 8: output word width; minimum 2.
- REP_LIMIT, default 16: run length of identical raw bits that trips the health test; minimum 2.
- clk  input  1  the single clock.
- rst_n  input  1  reset, asynchronous and active-low.
- enabled  input  1  1 = latches excited and sampling active.
- test_mode  input  1  1 = use test_bit instead of the latch XOR.
- test_bit  input  1  deterministic raw bit used in test mode.
- debias_en  input  1  1 = von Neumann debiasing on; 0 = every raw bit is accepted.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WORD_WIDTH  packed word, registered.
- out_valid  output  1  out_data holds an unconsumed word.
- health_fail  output  1  sticky repetition-count failure.
- b  output  1  registered raw sample bit (debug/compatibility).

## Operation
- Latch drive: while enabled=0, every latch is held in its reset state (s=0, r=1). While enabled=1, both s and r are driven by clk to provoke a metastable resolution.
- Sample stage: on every posedge with enabled=1, sample_r is loaded with test_bit if test_mode=1, otherwise with the XOR of all latch q outputs. b mirrors sample_r.
- The conditioning stage evaluates sample_r one edge after it is loaded. It only acts when enabled was 1 on the loading edge; a per-sample valid flag tracks this.
- Health test:
  - run counter: first sample after enable = 1; +1 when a sample equals the previous one, otherwise reset to 1; saturates at REP_LIMIT.
  - Trip: on the edge where the run reaches REP_LIMIT, health_fail is set and the triggering bit is not accumulated.
  - While health_fail=1: accumulator, pending word and output register are cleared, out_valid is held at 0, and nothing is produced.
  - Only rst_n clears health_fail.
- Debiaser (debias_en=1) has two states:
  - EMPTY: store the bit and go to HALF.
  - HALF: if the new bit differs from the stored bit, emit the stored bit; if equal, discard both. Return to EMPTY either way.
  - debias_en=0 bypasses the debiaser and emits every evaluated bit.
  - Changing debias_en mid-stream returns the debiaser to EMPTY.
- Accumulator:
  - Emitted bits shift in at bit 0 (shift left), so the first bit of a word ends up in the MSB. The bit counter runs 0..WORD_WIDTH.
  - On the edge that inserts bit WORD_WIDTH, the word loads directly into out_data, out_valid is set and the counter clears. This happens only if the output slot is free, i.e. out_valid=0 or out_ready=1 on that edge.
  - If the slot is busy, the completed word is held (counter = WORD_WIDTH). Further emitted bits are discarded. The held word loads on the first edge where out_valid and out_ready are both 1, giving back-to-back words.
- Output handshake: out_data is stable while out_valid=1 and out_ready=0. On an edge with out_valid and out_ready both 1 and no held word, out_valid drops.
- enabled falling to 0: the debiaser returns to EMPTY, the run counter clears, and a partial (incomplete) accumulator word is discarded. A held complete word and the output register are kept.
- Reset: all state clears immediately and asynchronously. out_data=0, out_valid=0, health_fail=0, b=0, counters 0, debiaser EMPTY, latches in the reset-hold state.

## Timing
- A raw bit presented before edge k is in sample_r/b after edge k and accumulated at edge k+1.
- With debias off, the last bit of a word sampled at edge k gives out_valid=1 after edge k+1.
- With debias on, an emitted bit comes from the second sample of its pair, with the same latency of one edge after that sample.
- health_fail rises after the edge that evaluates the REP_LIMIT-th identical bit. out_valid falls on the same edge.
- When a handshake completes and the held word loads on the same edge, out_valid stays 1 with no gap.

## Test plan
- Reset: rst_n=0 asynchronously mid-cycle -> out_data=0, out_valid=0, health_fail=0, b=0 with no clock edge needed.
- Packing: test_mode=1, debias_en=0, enabled=1, out_ready=0, feed 1,0,1,1,0,0,1,0 at edges 1-8 -> out_valid=1 after edge 9, out_data=8'hB2, held stable for 20 cycles.
- Debias: feed pairs 10,11,01,00,10,01,10,01,01,10,01,10 -> discarded pairs skipped; the emitted bits 1,0,1,0,1,0,0,1,0,1 make the first word 8'hA9 (emitted bits 9-10 remain in the accumulator).
- Backpressure: out_ready=0, produce words 8'hB2 then 8'h4D (held), then feed 8 more bits (discarded); pulse out_ready for one cycle -> 8'hB2 consumed, out_valid stays 1 with 8'h4D, and no third word appears.
- Health: REP_LIMIT=16, feed 16 consecutive 1s -> one 8'hFF word appears, then health_fail=1 after the 16th bit is evaluated, out_valid=0, no further words; it stays set despite enabled toggling until rst_n pulses.
- Mid-word disruptions:
  - enabled drops after 5 bits -> those bits are discarded, and the next word needs 8 fresh bits.
  - rst_n asserted mid-word -> all outputs 0, and the same 8-fresh-bit requirement applies after release.
